// File: rtl/avalon_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit: memory opcodes,
// FSM states, byte-lane enable patterns and byte-mask helpers.
package mips_mem_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_load(input mem_op_t op);
    logic res;
    case (op)
      LB, LBU, LH, LHU, LW, LWL, LWR: res = 1'b1;
      default:                        res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_store(input mem_op_t op);
    logic res;
    case (op)
      SB, SH, SW: res = 1'b1;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

  // Mask covering the n least-significant bytes of a word.
  function automatic logic [31:0] low_bytes_mask(input logic [1:0] n);
    logic [31:0] res;
    case (n)
      2'd0:    res = 32'h0000_0000;
      2'd1:    res = 32'h0000_00FF;
      2'd2:    res = 32'h0000_FFFF;
      2'd3:    res = 32'h00FF_FFFF;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Mask covering the n most-significant bytes of a word.
  function automatic logic [31:0] high_bytes_mask(input logic [1:0] n);
    logic [31:0] res;
    case (n)
      2'd0:    res = 32'h0000_0000;
      2'd1:    res = 32'hFF00_0000;
      2'd2:    res = 32'hFFFF_0000;
      2'd3:    res = 32'hFFFF_FF00;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/avalon_lsu_if.sv
// CPU request/response handshake plus Avalon-MM data bus of the load/store unit.
// master: the LSU itself; slave: the CPU datapath and memory around it.
interface avalon_lsu_if;
  import mips_mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, waitrequest, readdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, waitrequest, readdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/avalon_lsu_lane_align.sv
// Combinational lane steering: byte enables and lane-shifted store data for the
// bus side, alignment check, and extended/merged load result from readdata.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [31:0] shifted_s;
  logic [4:0]  shamt_s;
  logic [4:0]  lwl_shamt_s;
  logic [1:0]  lwl_keep_s;

  assign shamt_s     = {offset, 3'b000};
  assign lwl_keep_s  = 2'd3 - offset;
  assign lwl_shamt_s = {lwl_keep_s, 3'b000};
  assign shifted_s   = rdata >> shamt_s;

  // Decode the op into lane enables, store data, alignment fault and load value.
  always_comb begin
    byteenable = BE_NONE;
    writedata  = 32'h0000_0000;
    misalign   = 1'b0;
    load_data  = 32'h0000_0000;
    case (op)
      LB: begin
        byteenable = BE_WORD;
        load_data  = {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      LBU: begin
        byteenable = BE_WORD;
        load_data  = {24'h00_0000, shifted_s[7:0]};
      end
      LH: begin
        byteenable = BE_WORD;
        misalign   = offset[0];
        load_data  = {{16{shifted_s[15]}}, shifted_s[15:0]};
      end
      LHU: begin
        byteenable = BE_WORD;
        misalign   = offset[0];
        load_data  = {16'h0000, shifted_s[15:0]};
      end
      LW: begin
        byteenable = BE_WORD;
        misalign   = (offset != 2'd0);
        load_data  = rdata;
      end
      LWL: begin
        byteenable = BE_WORD;
        load_data  = (rdata << lwl_shamt_s) | (rt & low_bytes_mask(lwl_keep_s));
      end
      LWR: begin
        byteenable = BE_WORD;
        load_data  = shifted_s | (rt & high_bytes_mask(offset));
      end
      SB: begin
        byteenable = BE_BYTE << offset;
        writedata  = {24'h00_0000, rt[7:0]} << shamt_s;
      end
      SH: begin
        misalign   = offset[0];
        byteenable = BE_HALF << offset;
        writedata  = {16'h0000, rt[15:0]} << shamt_s;
      end
      SW: begin
        misalign   = (offset != 2'd0);
        byteenable = BE_WORD;
        writedata  = rt;
      end
      // Unsupported opcodes are rejected the same way as misaligned accesses.
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/avalon_lsu.sv
// Load/store unit: accepts one memory op at a time, runs a single Avalon-MM
// transaction with waitrequest stall and timeout, then pulses a response.
module avalon_lsu
  import mips_mem_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset,
  avalon_lsu_if.master bus
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lsu_state_t        state_r;
  lsu_state_t        state_next_s;
  mem_op_t           op_r;
  logic [1:0]        off_r;
  logic [31:0]       rt_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic [31:0]       address_r;
  logic              read_r;
  logic              write_r;
  logic [31:0]       writedata_r;
  logic [3:0]        byteenable_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic [31:0]       rsp_rdata_r;

  mem_op_t           al_op_s;
  logic [1:0]        al_off_s;
  logic [31:0]       al_rt_s;
  logic [3:0]        al_be_s;
  logic [31:0]       al_wd_s;
  logic              al_misalign_s;
  logic [31:0]       al_load_s;
  logic              timeout_s;

  // While idle the aligner looks at the incoming request; afterwards at the held op.
  always_comb begin
    al_op_s  = op_r;
    al_off_s = off_r;
    al_rt_s  = rt_r;
    if (state_r == IDLE) begin
      al_op_s  = bus.req_op;
      al_off_s = bus.req_addr[1:0];
      al_rt_s  = bus.req_wdata;
    end else begin
      al_op_s  = op_r;
      al_off_s = off_r;
      al_rt_s  = rt_r;
    end
  end

  lsu_lane_align u_align (
    .op         (al_op_s),
    .offset     (al_off_s),
    .rt         (al_rt_s),
    .rdata      (bus.readdata),
    .byteenable (al_be_s),
    .writedata  (al_wd_s),
    .misalign   (al_misalign_s),
    .load_data  (al_load_s)
  );

  assign timeout_s = bus.waitrequest && (wait_cnt_r == CNT_LAST);

  // Next-state logic for the IDLE -> BUS -> RESP -> IDLE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          if (al_misalign_s) begin
            state_next_s = RESP;
          end else begin
            state_next_s = BUS;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      BUS: begin
        if (!bus.waitrequest || timeout_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = BUS;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request capture, bus strobes, wait counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r         <= LB;
      off_r        <= 2'd0;
      rt_r         <= 32'h0000_0000;
      wait_cnt_r   <= '0;
      address_r    <= 32'h0000_0000;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      writedata_r  <= 32'h0000_0000;
      byteenable_r <= BE_NONE;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_rdata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            op_r        <= bus.req_op;
            off_r       <= bus.req_addr[1:0];
            rt_r        <= bus.req_wdata;
            address_r   <= {bus.req_addr[31:2], 2'b00};
            wait_cnt_r  <= '0;
            rsp_rdata_r <= 32'h0000_0000;
            if (al_misalign_s) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
            end else begin
              read_r       <= is_load(bus.req_op);
              write_r      <= is_store(bus.req_op);
              byteenable_r <= al_be_s;
              writedata_r  <= al_wd_s;
              rsp_err_r    <= 1'b0;
            end
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= is_load(op_r) ? al_load_s : 32'h0000_0000;
          end else if (timeout_s) begin
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= 32'h0000_0000;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
        default: begin
          read_r      <= 1'b0;
          write_r     <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.address    = address_r;
  assign bus.read       = read_r;
  assign bus.write      = write_r;
  assign bus.writedata  = writedata_r;
  assign bus.byteenable = byteenable_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.rsp_rdata  = rsp_rdata_r;

endmodule
